// File: rtl/interlock_pkg.sv
// Shared types and helpers for the route interlock arbiter.
// Mask and index widths are sized for the largest supported route count.
package interlock_pkg;

  localparam int unsigned MAX_ROUTES = 32;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned MASK_W     = MAX_ROUTES * MAX_ROUTES;
  localparam int unsigned MASK_IDX_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANTED   = 2'd1,
    ST_RELEASING = 2'd2
  } route_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Conflict bit for routes i and j; a route never conflicts with itself.
  function automatic logic conflicts(input logic [MASK_W-1:0] mask,
                                     input int unsigned       n,
                                     input int unsigned       i,
                                     input int unsigned       j);
    if (i == j) return 1'b0;
    return mask[MASK_IDX_W'(i * n + j)];
  endfunction

  // First set bit of eligible searching upward from ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_ROUTES-1:0] eligible,
                                       input int unsigned           ptr,
                                       input int unsigned           n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_ROUTES; k++) begin
      if (k < n) begin
        cand = ptr + k;
        if (cand >= n) cand = cand - n;
        if (!res.valid && eligible[IDX_W'(cand)]) begin
          res.valid = 1'b1;
          res.idx   = IDX_W'(cand);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/interlock_route_fsm.sv
// Per-route lock state machine: idle, granted, then a timed release hold-off.
module interlock_route_fsm
  import interlock_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         select,
  input  logic         i_req,
  output route_state_e state,
  output logic         o_grant,
  output logic         o_locked,
  output logic         o_grant_pulse
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      o_grant       <= 1'b0;
      o_locked      <= 1'b0;
      o_grant_pulse <= 1'b0;
    end else begin
      o_grant_pulse <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (select) begin
            state         <= ST_GRANTED;
            o_grant       <= 1'b1;
            o_locked      <= 1'b1;
            o_grant_pulse <= 1'b1;
          end
        end
        ST_GRANTED: begin
          if (!i_req) begin
            o_grant <= 1'b0;
            if (RELEASE_CYCLES == 0) begin
              state    <= ST_IDLE;
              o_locked <= 1'b0;
            end else begin
              state <= ST_RELEASING;
              cnt   <= CNT_W'(RELEASE_CYCLES - 1);
            end
          end
        end
        ST_RELEASING: begin
          // Requests are ignored here; the route must return to idle first.
          if (cnt == '0) begin
            state    <= ST_IDLE;
            o_locked <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          o_grant  <= 1'b0;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/interlock_arbiter.sv
// Round-robin route arbiter with conflict-matrix interlocking and release hold-off.
// At most one new route is granted per cycle; locks are held until released.
module interlock_arbiter
  import interlock_pkg::*;
#(
  parameter int unsigned                       N_ROUTES       = 8,
  parameter logic [N_ROUTES*N_ROUTES-1:0]      CONFLICT_MASK  = '0,
  parameter int unsigned                       RELEASE_CYCLES = 4,
  parameter int unsigned                       CNT_W          = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_ROUTES-1:0] i_req,
  input  logic [N_ROUTES-1:0] i_inhibit,
  output logic [N_ROUTES-1:0] o_grant,
  output logic [N_ROUTES-1:0] o_locked,
  output logic [N_ROUTES-1:0] o_grant_pulse,
  output logic                o_conflict_err
);

  localparam int unsigned PTR_W = (N_ROUTES > 1) ? $clog2(N_ROUTES) : 1;
  localparam logic [MASK_W-1:0] MASK_EXT = MASK_W'(CONFLICT_MASK);

  route_state_e        st [N_ROUTES];
  logic [N_ROUTES-1:0] blocked_c;
  logic [N_ROUTES-1:0] eligible_c;
  logic [N_ROUTES-1:0] select_c;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_nxt_c;
  rr_pick_t            pick_c;
  logic                err_c;
  int unsigned         nxt_c;

  // Eligibility uses registered lock state only.
  always_comb begin
    blocked_c  = '0;
    eligible_c = '0;
    for (int unsigned r = 0; r < N_ROUTES; r++) begin
      for (int unsigned j = 0; j < N_ROUTES; j++) begin
        if (conflicts(MASK_EXT, N_ROUTES, r, j) && o_locked[j]) blocked_c[r] = 1'b1;
      end
      eligible_c[r] = (st[r] == ST_IDLE) && i_req[r] && !i_inhibit[r] && !blocked_c[r];
    end
  end

  always_comb begin
    pick_c    = rr_pick(MAX_ROUTES'(eligible_c), 32'(ptr), N_ROUTES);
    select_c  = '0;
    for (int unsigned r = 0; r < N_ROUTES; r++) begin
      select_c[r] = pick_c.valid && (32'(pick_c.idx) == r);
    end
    nxt_c = 32'(pick_c.idx) + 32'd1;
    if (nxt_c >= N_ROUTES) nxt_c = 32'd0;
    ptr_nxt_c = pick_c.valid ? PTR_W'(nxt_c) : ptr;
  end

  // Defensive check: two mutually conflicting routes locked together.
  always_comb begin
    err_c = 1'b0;
    for (int unsigned i = 0; i < N_ROUTES; i++) begin
      for (int unsigned j = i + 1; j < N_ROUTES; j++) begin
        if (conflicts(MASK_EXT, N_ROUTES, i, j) && o_locked[i] && o_locked[j]) err_c = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr            <= '0;
      o_conflict_err <= 1'b0;
    end else begin
      ptr            <= ptr_nxt_c;
      o_conflict_err <= o_conflict_err | err_c;
    end
  end

  for (genvar g = 0; g < N_ROUTES; g++) begin : g_route
    interlock_route_fsm #(
      .RELEASE_CYCLES(RELEASE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_fsm (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .select       (select_c[g]),
      .i_req        (i_req[g]),
      .state        (st[g]),
      .o_grant      (o_grant[g]),
      .o_locked     (o_locked[g]),
      .o_grant_pulse(o_grant_pulse[g])
    );
  end

endmodule

// File: doc/interlock_arbiter.md
Name: interlock_arbiter

Overview:
- Parametrised, clocked successor to the fixed per-signal ring interlock equations.
- Arbitrates route requests from N_ROUTES channels against a compile-time conflict matrix and grants at most one new route per cycle, in round-robin order.
- Holds each granted route locked until it is released, then keeps it locked for a flank-protection hold-off before any conflicting route may be granted.
- Sits between the route-request logic and the signal/point drive outputs.

Parameters:
- N_ROUTES, 8: number of routes/channels, 2..32.
- CONFLICT_MASK, all zeros, N_ROUTES*N_ROUTES bits: bit [i*N_ROUTES+j]=1 means route i conflicts with route j. Must be symmetric. Diagonal bits are ignored.
- RELEASE_CYCLES, 4: hold-off cycles after a release, 0..255. A value of 0 means the route goes straight to idle.
- CNT_W, 8: width of each release counter; must be able to hold RELEASE_CYCLES.

Ports:
- i_clk, in, 1: system clock, rising edge.
- i_rst, in, 1: asynchronous, active-high reset.
- i_req, in, N_ROUTES: per-route request, level. Held high while the route is wanted.
- i_inhibit, in, N_ROUTES: external inhibit (e.g. section occupied). Blocks new grants only.
- o_grant, out, N_ROUTES: route is granted (GRANTED state).
- o_locked, out, N_ROUTES: route is GRANTED or RELEASING.
- o_grant_pulse, out, N_ROUTES: one-cycle pulse in the cycle o_grant rises.
- o_conflict_err, out, 1: sticky. Set if two mutually conflicting routes are ever both locked.

Behaviour:
- Reset (async assert, sync release):
  - every route in IDLE, all counters 0, round-robin pointer 0;
  - o_grant, o_locked, o_grant_pulse all 0; o_conflict_err 0.
- Per-route FSM (3 states):
  - IDLE -> GRANTED when the arbiter selects the route.
  - GRANTED -> RELEASING when i_req[r]=0 (RELEASE_CYCLES>0); the counter loads RELEASE_CYCLES-1. With RELEASE_CYCLES=0, GRANTED -> IDLE directly.
  - RELEASING: the counter decrements each cycle; the route goes to IDLE when the counter is 0. The hold-off is exactly RELEASE_CYCLES cycles with o_locked high.
  - Re-asserting i_req during RELEASING is ignored. The route must reach IDLE and then win arbitration again.
- Eligibility of route r in a cycle, all of the following required:
  - state IDLE;
  - i_req[r]=1;
  - i_inhibit[r]=0;
  - no route j with CONFLICT_MASK[r][j]=1 and o_locked[j]=1.
  Eligibility is evaluated on registered state; the current cycle's pending grant is not considered.
- Arbitration:
  - At most one grant per cycle: the first eligible route searching upward from the pointer, with wrap-around.
  - After a grant to route r, the pointer becomes (r+1) mod N_ROUTES. With no grant, the pointer is unchanged.
- Latency: i_req rising at edge t, with the route eligible, gives o_grant high after edge t+1. Outputs are registered.
- o_grant_pulse is high exactly the first cycle o_grant is high.
- Simultaneous events:
  - A request drop and its own grant in the same cycle: no grant, because eligibility requires i_req=1.
  - Release of route a and a request for a conflicting route b in the same cycle: b stays blocked until a reaches IDLE.
- i_inhibit rising while a route is GRANTED has no effect on that route.
- o_conflict_err:
  - Registered OR over all pairs i<j of CONFLICT_MASK[i][j] & o_locked[i] & o_locked[j].
  - Cleared only by reset. It is a defensive check and must never fire in correct operation.
- Reset mid-operation: all locks are dropped immediately (asynchronously). Requesters re-arbitrate after reset release.

Decomposition:
- interlock_pkg holds:
  - route state enum {ST_IDLE, ST_GRANTED, ST_RELEASING};
  - function conflicts(mask, i, j), returning the mask bit and masking off the diagonal;
  - function rr_pick(eligible, ptr), returning the index and a valid flag.
- Sub-module interlock_route_fsm, one instance per route via generate:
  - inputs: i_clk, i_rst, select, i_req;
  - outputs: state, o_grant, o_locked, o_grant_pulse;
  - owns the release counter.
- The top level holds eligibility, the round-robin pointer and the error check.

Test Plan (N_ROUTES=8, CONFLICT_MASK: 0<->1, 0<->2, 3<->4; RELEASE_CYCLES=4):
1. Reset, then i_req=8'h01 -> o_grant[0]=1 and o_grant_pulse[0]=1 one cycle later; the pulse drops the next cycle; o_locked=8'h01.
2. Route 0 granted, then i_req[1]=1 -> no grant to 1. Drop i_req[0] -> o_locked[0] stays high 4 cycles; o_grant[1] rises on the cycle after route 0 reaches IDLE.
3. i_req=8'h18 (routes 3 and 4) in the same cycle from reset -> route 3 granted, route 4 blocked and never granted while 3 is locked; o_conflict_err stays 0.
4. i_req=8'hE0 with the pointer at 0 -> grants 5, 6, 7 on three consecutive cycles, one per cycle; the pointer wraps to 0.
5. i_inhibit[2]=1 with i_req[2]=1 -> no grant. Clear the inhibit -> grant the next cycle. Set the inhibit while granted -> grant retained.
6. Assert i_rst asynchronously mid-cycle with routes 0 and 3 locked -> o_grant, o_locked and o_grant_pulse go to 0 without waiting for a clock edge. After release with requests held, routes 0 and 3 are re-granted in pointer order.
